// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM encodings, the IO
// window base and access-length decoding.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  // Lowest address treated as memory-mapped IO (writes there honour io_buffer_full).
  localparam logic [31:0] IO_ADDR_LO_DEF = 32'h0003_0000;

  // Access lengths as presented by the LSB (in bits).
  localparam logic [5:0] LEN_BYTE = 6'd8;
  localparam logic [5:0] LEN_HALF = 6'd16;
  localparam logic [5:0] LEN_WORD = 6'd32;

  // Matching byte counts.
  localparam logic [2:0] NB_BYTE = 3'd1;
  localparam logic [2:0] NB_HALF = 3'd2;
  localparam logic [2:0] NB_WORD = 3'd4;

  // Any unrecognised length degrades to a single byte.
  function automatic logic [2:0] len_to_nbytes(input logic [5:0] len);
    case (len)
      LEN_HALF: return NB_HALF;
      LEN_WORD: return NB_WORD;
      default:  return NB_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request/response signals and the byte-wide RAM/IO bus,
// bundled so the controller and its environment share one port list.
interface mem_ctrl_if;
  // global control
  logic        rdy;
  logic        flush;
  // load/store buffer
  logic        ld_req;
  logic        st_req;
  logic [5:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_data;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        st_pending;
  // instruction fetcher
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  // RAM / IO bus
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  // Environment side: the CPU core and the RAM port.
  modport master (
    output rdy, flush, ld_req, st_req, lsb_len, lsb_addr, lsb_data,
    output if_req, if_addr, mem_din, io_buffer_full,
    input  ld_done, ld_data, st_pending, if_done, if_data,
    input  mem_dout, mem_a, mem_wr
  );

  // Controller side.
  modport slave (
    input  rdy, flush, ld_req, st_req, lsb_len, lsb_addr, lsb_data,
    input  if_req, if_addr, mem_din, io_buffer_full,
    output ld_done, ld_data, st_pending, if_done, if_data,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_store_buf.sv
// Single-entry store latch. Captures a store pulse at any time, keeps a
// pending flag until the controller reports the last byte written, and
// presents the address/data of a selected byte of the entry. While st_req
// is high the incoming store is forwarded directly so the controller can
// begin writing on the very edge the store is captured.
module mem_ctrl_store_buf
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [5:0]  st_len,
  input  logic        clr,
  input  logic [1:0]  byte_idx,
  output logic        pending,
  output logic [2:0]  nbytes,
  output logic [31:0] byte_addr,
  output logic [7:0]  byte_data
);

  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic        pending_q, pending_d;

  logic [31:0] eff_addr;
  logic [31:0] eff_data;

  // Next-state: a new store always wins; otherwise the controller may retire the entry.
  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    nbytes_d  = nbytes_q;
    pending_d = pending_q;
    if (st_req) begin
      addr_d    = st_addr;
      data_d    = st_data;
      nbytes_d  = len_to_nbytes(st_len);
      pending_d = 1'b1;
    end else if (clr) begin
      pending_d = 1'b0;
    end
  end

  // Entry registers; frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      nbytes_q  <= '0;
      pending_q <= 1'b0;
    end else if (rdy) begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      nbytes_q  <= nbytes_d;
      pending_q <= pending_d;
    end
  end

  // Byte view of the entry (forwarded from the inputs on the capture cycle).
  always_comb begin
    eff_addr  = st_req ? st_addr : addr_q;
    eff_data  = st_req ? st_data : data_q;
    nbytes    = st_req ? len_to_nbytes(st_len) : nbytes_q;
    byte_addr = eff_addr + {30'd0, byte_idx};
    case (byte_idx)
      2'd0:    byte_data = eff_data[7:0];
      2'd1:    byte_data = eff_data[15:8];
      2'd2:    byte_data = eff_data[23:16];
      default: byte_data = eff_data[31:24];
    endcase
  end

  assign pending = pending_q;

endmodule

// File: rtl/mem_ctrl.sv
// Memory-side responder: serialises loads, stores and instruction fetches
// onto a byte-wide synchronous RAM/IO bus. Reads return assembled,
// zero-extended data with a one-cycle done pulse; stores are buffered and
// written byte by byte with optional IO back-pressure.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_ADDR_LO = IO_ADDR_LO_DEF
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  mc_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;        // READ: edges since acceptance; WRITE: bytes issued
  logic [2:0]  nbytes_q, nbytes_d;  // READ length in bytes
  logic        fetch_q, fetch_d;    // current READ belongs to the fetcher
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        ld_done_q, ld_done_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;

  logic        sb_clr;
  logic [1:0]  wr_idx;
  logic        sb_pending;
  logic [2:0]  sb_nbytes;
  logic [31:0] sb_addr;
  logic [7:0]  sb_byte;
  logic        io_stall;
  logic [31:0] rdata_merged;

  // Byte k of the store is always selected by the count of bytes already issued.
  assign wr_idx   = (state_q == MC_WRITE) ? cnt_q[1:0] : 2'd0;
  assign io_stall = (sb_addr >= IO_ADDR_LO) && bus.io_buffer_full;

  mem_ctrl_store_buf u_store_buf (
    .clk       (clk),
    .rst       (rst),
    .rdy       (bus.rdy),
    .st_req    (bus.st_req),
    .st_addr   (bus.lsb_addr),
    .st_data   (bus.lsb_data),
    .st_len    (bus.lsb_len),
    .clr       (sb_clr),
    .byte_idx  (wr_idx),
    .pending   (sb_pending),
    .nbytes    (sb_nbytes),
    .byte_addr (sb_addr),
    .byte_data (sb_byte)
  );

  // Controller next-state: arbitration, byte sequencing and flush handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    fetch_d    = fetch_q;
    rdata_d    = rdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ld_done_d  = 1'b0;
    ld_data_d  = ld_data_q;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    sb_clr     = 1'b0;

    // RAM data on this edge belongs to byte cnt_q-1 of the read.
    rdata_merged = rdata_q;
    for (int b = 0; b < 4; b++) begin
      if (cnt_q == 3'(b + 1)) rdata_merged[8*b +: 8] = bus.mem_din;
    end

    case (state_q)
      MC_IDLE: begin
        if (!bus.flush) begin
          if (bus.st_req || sb_pending) begin
            state_d = MC_WRITE;
            cnt_d   = 3'd0;
            if (!io_stall) begin
              mem_a_d    = sb_addr;
              mem_dout_d = sb_byte;
              mem_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end else if (bus.ld_req) begin
            state_d  = MC_READ;
            fetch_d  = 1'b0;
            nbytes_d = len_to_nbytes(bus.lsb_len);
            mem_a_d  = bus.lsb_addr;
            mem_wr_d = 1'b0;
            cnt_d    = 3'd0;
            rdata_d  = '0;
          end else if (bus.if_req) begin
            state_d  = MC_READ;
            fetch_d  = 1'b1;
            nbytes_d = NB_WORD;
            mem_a_d  = bus.if_addr;
            mem_wr_d = 1'b0;
            cnt_d    = 3'd0;
            rdata_d  = '0;
          end
        end
      end

      MC_READ: begin
        cnt_d   = cnt_q + 3'd1;
        rdata_d = rdata_merged;
        if (cnt_q < nbytes_q - 3'd1) mem_a_d = mem_a_q + 32'd1;
        if (cnt_q == nbytes_q) begin
          state_d = MC_IDLE;
          cnt_d   = 3'd0;
          mem_a_d = '0;
          if (fetch_q) begin
            if_done_d = 1'b1;
            if_data_d = rdata_merged;
          end else begin
            ld_done_d = 1'b1;
            ld_data_d = rdata_merged;
          end
        end
      end

      MC_WRITE: begin
        if (cnt_q == sb_nbytes) begin
          state_d    = MC_IDLE;
          cnt_d      = 3'd0;
          mem_a_d    = '0;
          mem_dout_d = '0;
          mem_wr_d   = 1'b0;
          sb_clr     = 1'b1;
        end else if (io_stall) begin
          mem_wr_d = 1'b0;
        end else begin
          mem_a_d    = sb_addr;
          mem_dout_d = sb_byte;
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = MC_IDLE;
      end
    endcase

    // Flush kills any read and clears the response outputs; committed stores keep going.
    if (bus.flush) begin
      ld_done_d = 1'b0;
      if_done_d = 1'b0;
      ld_data_d = '0;
      if_data_d = '0;
      if (state_q != MC_WRITE) begin
        state_d    = MC_IDLE;
        cnt_d      = 3'd0;
        nbytes_d   = 3'd0;
        fetch_d    = 1'b0;
        rdata_d    = '0;
        mem_a_d    = '0;
        mem_dout_d = '0;
        mem_wr_d   = 1'b0;
      end
    end
  end

  // Controller state and registered outputs; everything holds while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MC_IDLE;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      fetch_q    <= 1'b0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_data_q  <= '0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
    end else if (bus.rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      fetch_q    <= fetch_d;
      rdata_q    <= rdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ld_done_q  <= ld_done_d;
      ld_data_q  <= ld_data_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
    end
  end

  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.ld_done    = ld_done_q;
  assign bus.ld_data    = ld_data_q;
  assign bus.if_done    = if_done_q;
  assign bus.if_data    = if_data_q;
  assign bus.st_pending = sb_pending;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int ld_pulses = 0;
  int if_pulses = 0;

  // RAM model: read data one cycle after the address, frozen while rdy is low.
  logic [7:0] ram [0:262143];
  always @(posedge clk) begin
    if (rst) begin
      ram[18'h00100] = 8'h13;
      ram[18'h00101] = 8'h05;
      ram[18'h00102] = 8'h00;
      ram[18'h00103] = 8'h00;
      ram[18'h02001] = 8'hFE;
      ram[18'h02002] = 8'hFF;
      ram[18'h02003] = 8'h00;
      ram[18'h02004] = 8'h00;
      bus.mem_din <= 8'h00;
    end else if (bus.rdy) begin
      if (bus.mem_wr) ram[bus.mem_a[17:0]] = bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[17:0]];
    end
  end

  // Count response pulses over the whole run.
  always @(negedge clk) begin
    if (!rst && bus.ld_done) ld_pulses++;
    if (!rst && bus.if_done) if_pulses++;
  end

  // The bench itself must never re-send a store while one is pending.
  always @(posedge clk) begin
    if (!rst) assert (!(bus.st_req && bus.st_pending)) else $error("st_req while st_pending");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full read transaction with fixed timing: accept at E0, done at E(N+1).
  task automatic rd_txn(input bit fetch, input logic [31:0] addr, input logic [5:0] len,
                        input logic [31:0] exp, input string tag);
    int n;
    n = fetch ? 4 : int'(len) / 8;
    if (fetch) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.ld_req = 1'b1; bus.lsb_addr = addr; bus.lsb_len = len;
    end
    tick();
    chk({tag, "_a0"}, bus.mem_a, addr);
    chk({tag, "_wr"}, {31'd0, bus.mem_wr}, 32'd0);
    for (int k = 1; k < n; k++) begin
      tick();
      chk({tag, "_a"}, bus.mem_a, addr + 32'(k));
    end
    tick();
    chk({tag, "_early"}, {31'd0, fetch ? bus.if_done : bus.ld_done}, 32'd0);
    tick();
    chk({tag, "_done"}, {31'd0, fetch ? bus.if_done : bus.ld_done}, 32'd1);
    chk({tag, "_data"}, fetch ? bus.if_data : bus.ld_data, exp);
    bus.if_req = 1'b0;
    bus.ld_req = 1'b0;
    tick();
    chk({tag, "_pulse"}, {31'd0, fetch ? bus.if_done : bus.ld_done}, 32'd0);
    chk({tag, "_idle"}, bus.mem_a, 32'd0);
    $display("txn %s fetch=%0d addr=%h data=%h", tag, fetch, addr, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.ld_req = 1'b0; bus.st_req = 1'b0;
    bus.lsb_len = 6'd0; bus.lsb_addr = '0; bus.lsb_data = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.io_buffer_full = 1'b0;
    repeat (3) tick();
    chk("rst_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_a", bus.mem_a, 32'd0);
    chk("rst_pend", {31'd0, bus.st_pending}, 32'd0);
    chk("rst_done", {30'd0, bus.ld_done, bus.if_done}, 32'd0);
    rst = 1'b0;
    $display("txn reset");

    // Fetch, word load, unaligned halfword load.
    rd_txn(1'b1, 32'h100, 6'd32, 32'h0000_0513, "fetch");
    rd_txn(1'b0, 32'h100, 6'd32, 32'h0000_0513, "ldw");
    rd_txn(1'b0, 32'h2001, 6'd16, 32'h0000_FFFE, "ldh");

    // Store with a fetch waiting: four writes, then the fetch at E5.
    bus.st_req = 1'b1; bus.lsb_len = 6'd32; bus.lsb_addr = 32'h400; bus.lsb_data = 32'hDEAD_BEEF;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] wd;
      wd = 32'hDEAD_BEEF >> (8 * k);
      tick();
      bus.st_req = 1'b0;
      chk("st_wr", {31'd0, bus.mem_wr}, 32'd1);
      chk("st_a", bus.mem_a, 32'h400 + 32'(k));
      chk("st_dout", {24'd0, bus.mem_dout}, {24'd0, wd[7:0]});
      chk("st_pend", {31'd0, bus.st_pending}, 32'd1);
    end
    tick();
    chk("st_end_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("st_end_pend", {31'd0, bus.st_pending}, 32'd0);
    tick();
    chk("st_fetch_a0", bus.mem_a, 32'h100);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("st_fetch_a", bus.mem_a, 32'h100 + 32'(k));
    end
    tick();
    chk("st_fetch_early", {31'd0, bus.if_done}, 32'd0);
    tick();
    chk("st_fetch_done", {31'd0, bus.if_done}, 32'd1);
    chk("st_fetch_data", bus.if_data, 32'h0000_0513);
    bus.if_req = 1'b0;
    tick();
    chk("st_ram", {ram[18'h403], ram[18'h402], ram[18'h401], ram[18'h400]}, 32'hDEAD_BEEF);
    $display("txn store addr=00000400 data=deadbeef");

    // IO store held off by io_buffer_full for three cycles.
    bus.io_buffer_full = 1'b1;
    bus.st_req = 1'b1; bus.lsb_len = 6'd8; bus.lsb_addr = 32'h0003_0000; bus.lsb_data = 32'h1234_565A;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.st_req = 1'b0;
      chk("io_stall_wr", {31'd0, bus.mem_wr}, 32'd0);
      chk("io_stall_pend", {31'd0, bus.st_pending}, 32'd1);
    end
    bus.io_buffer_full = 1'b0;
    tick();
    chk("io_wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("io_a", bus.mem_a, 32'h0003_0000);
    chk("io_dout", {24'd0, bus.mem_dout}, 32'h5A);
    tick();
    chk("io_end_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("io_end_pend", {31'd0, bus.st_pending}, 32'd0);
    chk("io_ram", {24'd0, ram[18'h30000]}, 32'h5A);
    $display("txn io store addr=00030000 data=5a");

    // Word load flushed at E2; requester still high in the flush cycle.
    bus.ld_req = 1'b1; bus.lsb_len = 6'd32; bus.lsb_addr = 32'h100;
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    chk("fl_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("fl_a", bus.mem_a, 32'd0);
    chk("fl_done", {31'd0, bus.ld_done}, 32'd0);
    bus.flush = 1'b0;
    bus.ld_req = 1'b0;
    $display("txn flushed load addr=00000100");
    rd_txn(1'b1, 32'h2001, 6'd32, 32'h0000_FFFE, "fl_fetch");

    // Store pulse together with flush in the middle of a fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    tick();
    bus.if_req = 1'b0; bus.flush = 1'b1;
    bus.st_req = 1'b1; bus.lsb_len = 6'd16; bus.lsb_addr = 32'h500; bus.lsb_data = 32'h0000_CAFE;
    tick();
    bus.flush = 1'b0; bus.st_req = 1'b0;
    chk("fs_pend", {31'd0, bus.st_pending}, 32'd1);
    chk("fs_wr0", {31'd0, bus.mem_wr}, 32'd0);
    tick();
    chk("fs_wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("fs_a", bus.mem_a, 32'h500);
    chk("fs_dout", {24'd0, bus.mem_dout}, 32'hFE);
    tick();
    chk("fs_a1", bus.mem_a, 32'h501);
    chk("fs_dout1", {24'd0, bus.mem_dout}, 32'hCA);
    tick();
    chk("fs_end_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("fs_end_pend", {31'd0, bus.st_pending}, 32'd0);
    chk("fs_ram", {16'd0, ram[18'h501], ram[18'h500]}, 32'h0000_CAFE);
    $display("txn store under flush addr=00000500 data=cafe");

    // Byte load with rdy dropped for three cycles after acceptance.
    bus.ld_req = 1'b1; bus.lsb_len = 6'd8; bus.lsb_addr = 32'h2002;
    tick();
    chk("rdy_a0", bus.mem_a, 32'h2002);
    bus.rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rdy_hold_a", bus.mem_a, 32'h2002);
      chk("rdy_hold_done", {31'd0, bus.ld_done}, 32'd0);
    end
    bus.rdy = 1'b1;
    tick();
    chk("rdy_early", {31'd0, bus.ld_done}, 32'd0);
    tick();
    chk("rdy_done", {31'd0, bus.ld_done}, 32'd1);
    chk("rdy_data", bus.ld_data, 32'h0000_00FF);
    bus.ld_req = 1'b0;
    tick();
    $display("txn byte load with rdy stall addr=00002002 data=ff");

    // Aborted reads must not have produced any done pulse.
    chk("ld_pulse_count", 32'(ld_pulses), 32'd3);
    chk("if_pulse_count", 32'(if_pulses), 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory-side responder for the load/store buffer and the instruction fetcher.
- Accepts word/halfword/byte load requests, fire-and-forget store pulses and instruction-fetch requests.
- Serialises them onto the single byte-wide synchronous RAM/IO bus and returns assembled read data with a one-cycle done pulse.
- Sits between the CPU core (LSB, IFetch) and the top-level RAM port.

Parameters:
- IO_ADDR_LO, 32'h0003_0000, lowest address treated as memory-mapped IO (writes stall on io_buffer_full).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; when low, all state and outputs hold
- flush  in  1  branch mispredict; aborts in-flight load/fetch
- ld_req  in  1  LSB load request, level, held until ld_done
- st_req  in  1  LSB store pulse, one cycle, never re-sent
- lsb_len  in  6  access length in bits: 8, 16, 32
- lsb_addr  in  32  byte address (load or store)
- lsb_data  in  32  store data, low lsb_len bits used
- ld_done  out  1  one-cycle pulse, load data valid
- ld_data  out  32  load result, zero-extended raw bytes
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse, instruction valid
- if_data  out  32  fetched instruction
- st_pending  out  1  store latched but not fully written
- mem_din  in  8  RAM read byte (valid one cycle after address)
- io_buffer_full  in  1  IO write back-pressure
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read

Behaviour:
- Reset values: all outputs 0, state IDLE, store buffer empty. The same values apply on flush, except that the store buffer and an in-progress WRITE are preserved, because stores are already committed.
- Store buffer:
  - one entry {addr, data, nbytes}; loaded on any cycle where st_req=1, including while busy.
  - st_pending=1 from the edge after capture until the last byte is written.
  - st_req while st_pending=1 is a protocol violation; the bench asserts this never happens.
- Arbitration in IDLE, fixed priority: pending store > ld_req > if_req.
  - A request is accepted at edge E0; the outputs it drives are registered.
- States: IDLE, READ, WRITE.
- READ of N bytes (N = len/8 for loads, 4 for fetch):
  - E0: mem_a <= addr, mem_wr <= 0, byte counter reset.
  - Edges E1..E(N-1): mem_a increments by one each edge.
  - Byte i is captured from mem_din at E(i+2) into bits [8i+7:8i].
  - At E(N+1): done pulse and data register asserted, state -> IDLE.
  - Next acceptance no earlier than E(N+2).
- WRITE of N bytes:
  - Edge E(k), k=0..N-1: mem_a <= addr+k, mem_dout <= byte k, mem_wr <= 1.
  - At EN: mem_wr <= 0, st_pending <= 0, state -> IDLE.
  - Stall: if addr >= IO_ADDR_LO and io_buffer_full=1, that byte is not issued; mem_wr=0 and the counter holds.
- Idle bus: mem_wr=0, mem_a=0.
- flush during READ: the transaction is abandoned at that edge, no done pulse is produced and the state -> IDLE. A requester that re-asserts in the same cycle is ignored until the next edge.
- flush with st_req in the same cycle: the store is still captured.
- rdy=0: complete freeze, including the byte counter; RAM latency is assumed to be frozen externally.
- Unaligned addresses are legal (byte-serial); address arithmetic wraps mod 2^32.
- Upper ld_data bits beyond len are 0; sign extension belongs to the LSB.

Decomposition:
- Shared package / def.v additions: state encodings (MC_IDLE, MC_READ, MC_WRITE), IO_ADDR_LO, length-to-byte-count constants.
- One natural sub-module, mc_store_buf: single-entry store latch with pending flag and byte extraction; everything else is inline in mem_ctrl.

Test Plan:
- if_req, if_addr=0x100, RAM bytes 13,05,00,00 -> if_done in the cycle after E5, if_data=0x00000513; mem_a sequence 100..103.
- ld_req, lsb_len=16, addr=0x2001, RAM bytes 0xFE,0xFF -> ld_done after E3, ld_data=0x0000FFFE.
- st_req pulse, lsb_len=32, addr=0x400, data=0xDEADBEEF with if_req high -> 4 writes EF,BE,AD,DE at 0x400..0x403 with mem_wr=1; fetch starts at E5.
- Store to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then writes the byte; st_pending clears one edge after.
- ld_req word, flush asserted at E2 -> no ld_done ever, mem_wr=0, back to IDLE; a subsequent if_req is accepted at the next edge.
- Store pulse coincident with flush mid-fetch -> fetch aborted, store fully written, st_pending 1 -> 0.
